imem_responder: RTL

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// imem_responder : single-outstanding instruction fetch responder with a
//                  fixed-latency word store and a side loader write port.
// Revision 1.0
// ============================================================================
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  input  logic [31:0] i_req_addr,
  output logic        o_req_ready,
  input  logic        i_flush,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_data,
  output logic [31:0] o_rsp_addr,
  output logic        o_rsp_err,
  input  logic        i_rsp_ready,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_addr,
  input  logic [31:0] i_wr_data
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  C_CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [31:0] C_NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic             w_load_rsp;

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [IDX_W-1:0] r_idx;
  logic             r_err;
  logic [31:0]      r_addr;
  logic [31:0]      r_rsp_data;
  logic [31:0]      r_rsp_addr;
  logic             r_rsp_err;

  logic [29:0]      w_req_word;
  logic             w_req_err;
  logic [29:0]      w_wr_word;
  logic             w_wr_ok;
  logic             w_accept;
  logic [IDX_W-1:0] w_cap_idx;
  logic             w_cap_err;
  logic [31:0]      w_cap_addr;

  // Offsets wrap modulo 2^32, so addresses below BASE_ADDR land far out of range.
  assign w_req_word = 30'((i_req_addr - BASE_ADDR) >> 2);
  assign w_req_err  = (i_req_addr[1:0] != 2'b00) ||
                      ({2'b00, w_req_word} >= 32'(DEPTH_WORDS));
  assign w_wr_word  = 30'((i_wr_addr - BASE_ADDR) >> 2);
  assign w_wr_ok    = i_wr_en && (i_wr_addr[1:0] == 2'b00) &&
                      ({2'b00, w_wr_word} < 32'(DEPTH_WORDS));

  assign o_req_ready = (r_state == S_IDLE) && !i_flush;
  assign w_accept    = o_req_ready && i_req_valid;

  // With LATENCY==1 the response is captured on the accepting edge itself.
  assign w_cap_idx  = (r_state == S_IDLE) ? w_req_word[IDX_W-1:0] : r_idx;
  assign w_cap_err  = (r_state == S_IDLE) ? w_req_err : r_err;
  assign w_cap_addr = (r_state == S_IDLE) ? i_req_addr : r_addr;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load_rsp  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt = S_RESP;
            w_cnt_nxt   = 4'd0;
            w_load_rsp  = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = C_CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (i_flush) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end else begin
          // The counter reaches zero on the same edge that enters RESP.
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            w_state_nxt = S_RESP;
            w_load_rsp  = 1'b1;
          end
        end
      end
      S_RESP: begin
        if (i_flush || i_rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_idx      <= '0;
      r_err      <= 1'b0;
      r_addr     <= 32'd0;
      r_rsp_data <= 32'd0;
      r_rsp_addr <= 32'd0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx  <= w_req_word[IDX_W-1:0];
        r_err  <= w_req_err;
        r_addr <= i_req_addr;
      end
      if (w_load_rsp) begin
        r_rsp_data <= w_cap_err ? C_NOP : r_mem[w_cap_idx];
        r_rsp_addr <= w_cap_addr;
        r_rsp_err  <= w_cap_err;
      end
    end
  end

  // Store is never reset; a same-edge read above sees the pre-write word.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) begin
      r_mem[w_wr_word[IDX_W-1:0]] <= i_wr_data;
    end
  end

  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_addr  = r_rsp_addr;
  assign o_rsp_err   = r_rsp_err;

endmodule
`default_nettype wire
